led_pattern_engine: RTL and testbench

Parametrised LED pattern generator: a WIDTH-bit pattern register that advances once per programmable period. Supports four modes: rotate left, rotate right, bounce (ping-pong), and hold. Also supports runtime pattern load, pause, and single-step. Sits between the board clock and the user LED bank; the period is driven from a config register or a constant tie-off.

---
 rtl/led_pattern_engine.sv | 165 ++++++++++++++++
 tb/tb_led_pattern_engine.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_engine.sv
// led_pattern_engine: WIDTH-bit LED pattern register that advances once per
// programmable period. Supports rotate left/right, bounce and hold modes,
// plus runtime load, pause and single-step. All outputs are registered.
module led_pattern_engine #(
    parameter int                 WIDTH         = 8,
    parameter logic [WIDTH-1:0]   RESET_PATTERN = WIDTH'(8'b0001_1111),
    parameter int                 CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] period,
    input  logic             load,
    input  logic [WIDTH-1:0] load_pattern,
    input  logic             step,
    output logic [WIDTH-1:0] leds,
    output logic             tick,
    output logic             dir
);

    localparam logic [1:0] MODE_ROTL   = 2'b00;
    localparam logic [1:0] MODE_ROTR   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Rotate pattern one position toward the MSB.
    function automatic logic [WIDTH-1:0] rot_left(input logic [WIDTH-1:0] p);
        return {p[WIDTH-2:0], p[WIDTH-1]};
    endfunction

    // Rotate pattern one position toward the LSB.
    function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] p);
        return {p[0], p[WIDTH-1:1]};
    endfunction

    // Bounce step: returns {new_dir, new_pattern}. When the leading edge of
    // the pattern reaches the end it travels toward, the direction flips and
    // the pattern moves the other way if the opposite end is free; a pattern
    // touching both ends (e.g. all ones) stays put while dir still flips.
    function automatic logic [WIDTH:0] bounce_next(input logic [WIDTH-1:0] p,
                                                   input logic             d);
        logic [WIDTH:0] r;
        r = {d, p};
        if (d == 1'b0) begin
            if (p[WIDTH-1] == 1'b0) begin
                r = {1'b0, rot_left(p)};
            end else if (p[0] == 1'b0) begin
                r = {1'b1, rot_right(p)};
            end else begin
                r = {1'b1, p};
            end
        end else begin
            if (p[0] == 1'b0) begin
                r = {1'b1, rot_right(p)};
            end else if (p[WIDTH-1] == 1'b0) begin
                r = {1'b0, rot_left(p)};
            end else begin
                r = {1'b0, p};
            end
        end
        return r;
    endfunction

    logic [WIDTH-1:0] leds_r;
    logic [WIDTH-1:0] leds_next_s;
    logic             dir_r;
    logic             dir_next_s;
    logic             tick_r;
    logic             tick_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [CNT_W-1:0] eff_period_s;
    logic             fire_s;
    logic             advance_s;
    logic [WIDTH:0]   bounce_s;

    // Effective period, period-expiry detect and the combined advance event.
    always_comb begin
        eff_period_s = CNT_ONE;
        fire_s       = 1'b0;
        advance_s    = 1'b0;
        if (period == CNT_ZERO) begin
            eff_period_s = CNT_ONE;
        end else begin
            eff_period_s = period;
        end
        // >= so that shrinking the period mid-count fires on the next edge
        if (enable && (cnt_r >= (eff_period_s - CNT_ONE))) begin
            fire_s = 1'b1;
        end else begin
            fire_s = 1'b0;
        end
        if (enable) begin
            advance_s = fire_s;
        end else begin
            advance_s = step;
        end
    end

    // Next-state for pattern, direction, tick and period counter.
    always_comb begin
        leds_next_s = leds_r;
        dir_next_s  = dir_r;
        tick_next_s = 1'b0;
        cnt_next_s  = cnt_r;
        bounce_s    = bounce_next(leds_r, dir_r);
        if (load) begin
            // load wins over any coincident advance, which is dropped
            leds_next_s = load_pattern;
            dir_next_s  = 1'b0;
            tick_next_s = 1'b0;
            cnt_next_s  = CNT_ZERO;
        end else begin
            if (enable) begin
                if (fire_s) begin
                    cnt_next_s = CNT_ZERO;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end else begin
                // paused (step included): counter keeps its value
                cnt_next_s = cnt_r;
            end
            if (advance_s) begin
                tick_next_s = 1'b1;
                case (mode)
                    MODE_ROTL:   leds_next_s = rot_left(leds_r);
                    MODE_ROTR:   leds_next_s = rot_right(leds_r);
                    MODE_BOUNCE: begin
                        leds_next_s = bounce_s[WIDTH-1:0];
                        dir_next_s  = bounce_s[WIDTH];
                    end
                    MODE_HOLD:   leds_next_s = leds_r;
                    default:     leds_next_s = leds_r;
                endcase
            end else begin
                tick_next_s = 1'b0;
            end
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            leds_r <= RESET_PATTERN;
            dir_r  <= 1'b0;
            tick_r <= 1'b0;
            cnt_r  <= CNT_ZERO;
        end else begin
            leds_r <= leds_next_s;
            dir_r  <= dir_next_s;
            tick_r <= tick_next_s;
            cnt_r  <= cnt_next_s;
        end
    end

    assign leds = leds_r;
    assign tick = tick_r;
    assign dir  = dir_r;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine (WIDTH=8, CNT_W=32).
// A behavioural model computes the expected outputs for every clock; they are
// queued when the stimulus is applied and popped/compared after the edge.
// Fixed expectations from the scenario walk-throughs are checked as well.
module tb_led_pattern_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] period = 32'd1;
    logic        load = 1'b0;
    logic [7:0]  load_pattern = 8'h00;
    logic        step = 1'b0;
    logic [7:0]  leds;
    logic        tick;
    logic        dir;

    typedef struct packed {
        logic [7:0] leds;
        logic       tick;
        logic       dir;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  m_leds = 8'h1F;
    logic        m_dir  = 1'b0;
    logic        m_tick = 1'b0;
    logic [31:0] m_cnt  = 32'd0;
    int          total  = 0;
    int          bad    = 0;
    int          ticks  = 0;

    led_pattern_engine #(.WIDTH(8), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .period(period),
        .load(load), .load_pattern(load_pattern), .step(step),
        .leds(leds), .tick(tick), .dir(dir)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: advance the model with the current inputs, queue the
    // expectation, let the DUT take the edge, then pop and compare.
    task automatic cycle();
        exp_t        e;
        logic [31:0] ep;
        logic        adv;
        ep  = (period == 32'd0) ? 32'd1 : period;
        adv = 1'b0;
        if (rst) begin
            m_leds = 8'h1F; m_dir = 1'b0; m_tick = 1'b0; m_cnt = 32'd0;
        end else if (load) begin
            m_leds = load_pattern; m_dir = 1'b0; m_tick = 1'b0; m_cnt = 32'd0;
        end else begin
            if (enable) begin
                if (m_cnt + 32'd1 >= ep) begin adv = 1'b1; m_cnt = 32'd0; end
                else m_cnt = m_cnt + 32'd1;
            end else if (step) begin
                adv = 1'b1;
            end
            m_tick = adv;
            if (adv) begin
                case (mode)
                    2'b00: m_leds = {m_leds[6:0], m_leds[7]};
                    2'b01: m_leds = {m_leds[0], m_leds[7:1]};
                    2'b10: begin
                        if (!m_dir && !m_leds[7])     m_leds = {m_leds[6:0], m_leds[7]};
                        else if (m_dir && !m_leds[0]) m_leds = {m_leds[0], m_leds[7:1]};
                        else begin
                            // reached the end: turn around, move if the other end is free
                            m_dir = ~m_dir;
                            if (m_dir && !m_leds[0])       m_leds = {m_leds[0], m_leds[7:1]};
                            else if (!m_dir && !m_leds[7]) m_leds = {m_leds[6:0], m_leds[7]};
                        end
                    end
                    default: ;
                endcase
            end
        end
        e.leds = m_leds; e.tick = m_tick; e.dir = m_dir;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("leds", 64'(leds), 64'(e.leds));
        check("tick", 64'(tick), 64'(e.tick));
        check("dir",  64'(dir),  64'(e.dir));
        if (tick === 1'b1) ticks++;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_load(input logic [7:0] p);
        load = 1'b1; load_pattern = p;
        cycle();
        load = 1'b0;
    endtask

    logic [7:0] bounce_exp [13] = '{8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h60,
                                    8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h06};
    logic       bounce_dir [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] frozen;

    initial begin
        // Reset state
        rst = 1'b1;
        cycle();
        check("rst_leds", 64'(leds), 64'h1F);
        check("rst_tick", 64'(tick), 64'h0);
        check("rst_dir",  64'(dir),  64'h0);
        rst = 1'b0;

        // 1. Rotate left, period 4
        period = 32'd4; mode = 2'b00; enable = 1'b1; ticks = 0;
        cycles(3);
        check("rotl_no_tick_early", 64'(tick), 64'h0);
        cycle();
        check("rotl_4", 64'(leds), 64'h3E);
        check("rotl_tick4", 64'(tick), 64'h1);
        cycles(4);
        check("rotl_8", 64'(leds), 64'h7C);
        cycles(24);
        check("rotl_32", 64'(leds), 64'h1F);
        check("rotl_tick_count", 64'(ticks), 64'd8);

        // 2. Bounce with period 1
        do_load(8'h03);
        mode = 2'b10; period = 32'd1;
        for (int i = 0; i < 13; i++) begin
            cycle();
            check("bounce_leds", 64'(leds), 64'(bounce_exp[i]));
            check("bounce_dir",  64'(dir),  64'(bounce_dir[i]));
        end

        // 3. Pause mid-count, single step, resume
        mode = 2'b00; period = 32'd4;
        do_load(8'h01);
        cycles(2);                      // counter now 2
        enable = 1'b0; ticks = 0; frozen = leds;
        cycles(20);
        check("pause_leds", 64'(leds), 64'(frozen));
        check("pause_ticks", 64'(ticks), 64'd0);
        step = 1'b1;
        cycle();
        step = 1'b0;
        check("step_leds", 64'(leds), 64'h02);
        check("step_tick", 64'(tick), 64'h1);
        cycle();
        check("step_single", 64'(tick), 64'h0);
        enable = 1'b1;
        cycle();
        check("resume_1", 64'(tick), 64'h0);
        cycle();
        check("resume_2", 64'(tick), 64'h1);
        check("resume_leds", 64'(leds), 64'h04);

        // 4. Load on the firing edge
        cycles(3);                      // counter now 3, next edge would fire
        do_load(8'hA5);
        check("coll_leds", 64'(leds), 64'hA5);
        check("coll_tick", 64'(tick), 64'h0);
        ticks = 0;
        cycles(3);
        check("coll_no_early", 64'(ticks), 64'd0);
        cycle();
        check("coll_full_period", 64'(tick), 64'h1);
        check("coll_rot", 64'(leds), 64'h4B);

        // 5a. Period 0 behaves as 1
        period = 32'd0; ticks = 0;
        cycles(5);
        check("p0_ticks", 64'(ticks), 64'd5);
        // 5b. Hold mode: ticks but no movement
        mode = 2'b11; period = 32'd1; frozen = leds; ticks = 0;
        cycles(4);
        check("hold_leds", 64'(leds), 64'(frozen));
        check("hold_ticks", 64'(ticks), 64'd4);
        // 5c. Shrink period mid-count
        mode = 2'b00; period = 32'd100;
        do_load(8'h11);
        cycles(50);
        check("shrink_wait", 64'(leds), 64'h11);
        period = 32'd3;
        cycle();
        check("shrink_tick", 64'(tick), 64'h1);
        check("shrink_leds", 64'(leds), 64'h22);
        // 5d. Bounce with all ones never shifts
        mode = 2'b10; period = 32'd1;
        do_load(8'hFF);
        cycles(6);
        check("bounce_ff", 64'(leds), 64'hFF);

        // 6. Reset during bounce with dir=1 and counter nonzero
        period = 32'd3;
        do_load(8'hC0);
        cycles(3);
        check("pre_rst_dir", 64'(dir), 64'h1);
        check("pre_rst_leds", 64'(leds), 64'h60);
        cycle();                        // counter now 1
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_rst_leds", 64'(leds), 64'h1F);
        check("mid_rst_dir",  64'(dir),  64'h0);
        check("mid_rst_tick", 64'(tick), 64'h0);
        ticks = 0;
        cycles(2);
        check("post_rst_wait", 64'(ticks), 64'd0);
        cycle();
        check("post_rst_tick", 64'(tick), 64'h1);
        check("post_rst_leds", 64'(leds), 64'h3E);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
